// File: rtl/key_expansion_128_if.sv
// Handshake bundle between the cipher-key source, the AES-128 key schedule
// and the round stage that consumes the round keys.
interface key_expansion_128_if #(
    parameter int KEY_WIDTH = 128
);
    logic                 key_valid_in;
    logic                 key_ready_out;
    logic [KEY_WIDTH-1:0] key_in;
    logic                 rk_valid_out;
    logic                 rk_ready_in;
    logic [KEY_WIDTH-1:0] rk_out;
    logic [3:0]           rk_index_out;
    logic                 busy_out;

    modport master (
        output key_valid_in, key_in, rk_ready_in,
        input  key_ready_out, rk_valid_out, rk_out, rk_index_out, busy_out
    );

    modport slave (
        input  key_valid_in, key_in, rk_ready_in,
        output key_ready_out, rk_valid_out, rk_out, rk_index_out, busy_out
    );
endinterface

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: latches one cipher key and emits round keys
// 0..10 in order, one per accepted output handshake.
module key_expansion_128 #(
    parameter int KEY_WIDTH  = 128,
    parameter int NUM_ROUNDS = 10
) (
    input logic               clk,
    input logic               rst,
    key_expansion_128_if.slave kx
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One schedule step: round key i from round key i-1, words w0 (MSB) .. w3 (LSB).
    function automatic logic [127:0] next_round_key(input logic [127:0] w, input logic [3:0] i);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word({w[23:0], w[31:24]}) ^ {rcon(i), 24'h0};
        w0 = w[127:96] ^ t;
        w1 = w[95:64]  ^ w0;
        w2 = w[63:32]  ^ w1;
        w3 = w[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t               state;
    logic                 vld_p0;
    logic                 busy_p0;
    logic [KEY_WIDTH-1:0] rk_p0;
    logic [3:0]           rk_idx_p0;
    logic [KEY_WIDTH-1:0] rk_next;
    logic                 rk_fire;

    assign rk_next = next_round_key(rk_p0, rk_idx_p0 + 4'd1);
    assign rk_fire = vld_p0 & kx.rk_ready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vld_p0    <= 1'b0;
            busy_p0   <= 1'b0;
            rk_p0     <= '0;
            rk_idx_p0 <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (kx.key_valid_in) begin
                        rk_p0     <= kx.key_in;
                        rk_idx_p0 <= 4'd0;
                        vld_p0    <= 1'b1;
                        busy_p0   <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    // Last round key leaves rk_out/rk_index_out parked for inspection.
                    if (rk_fire) begin
                        if (rk_idx_p0 == 4'(NUM_ROUNDS)) begin
                            vld_p0  <= 1'b0;
                            busy_p0 <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            rk_p0     <= rk_next;
                            rk_idx_p0 <= rk_idx_p0 + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kx.key_ready_out = (state == IDLE);
    assign kx.rk_valid_out  = vld_p0;
    assign kx.rk_out        = rk_p0;
    assign kx.rk_index_out  = rk_idx_p0;
    assign kx.busy_out      = busy_p0;

endmodule

// File: tb/tb_key_expansion_128.sv
// Randomized bench for key_expansion_128 against a word-array AES-128 key
// expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_expansion_128;

    logic clk;
    logic rst;

    key_expansion_128_if kx_if ();

    key_expansion_128 dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook 44-word expansion; round key k is words 4k..4k+3.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT idle; returns at T+12 with the DUT idle again.
    task automatic run_schedule(input logic [127:0] key, input int stall_idx, input bit poke);
        build_model(key);
        chk("key_ready_idle", 128'(kx_if.key_ready_out), 128'(1));
        kx_if.key_in       = key;
        kx_if.key_valid_in = 1'b1;
        kx_if.rk_ready_in  = 1'b1;
        tick();
        for (int k = 0; k <= 10; k++) begin
            kx_if.key_valid_in = 1'b0;
            chk("rk_valid", 128'(kx_if.rk_valid_out), 128'(1));
            chk("rk_index", 128'(kx_if.rk_index_out), 128'(k));
            chk("rk_out", kx_if.rk_out, exp_rk[k]);
            chk("busy", 128'(kx_if.busy_out), 128'(1));
            chk("key_ready_busy", 128'(kx_if.key_ready_out), 128'(0));
            got_rk[k] = kx_if.rk_out;
            if (k == stall_idx) begin
                kx_if.rk_ready_in = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_valid", 128'(kx_if.rk_valid_out), 128'(1));
                    chk("stall_index", 128'(kx_if.rk_index_out), 128'(k));
                    chk("stall_rk", kx_if.rk_out, exp_rk[k]);
                end
                kx_if.rk_ready_in = 1'b1;
            end
            if (poke && k == 2) begin
                kx_if.key_in       = '1;
                kx_if.key_valid_in = 1'b1;
            end
            tick();
        end
        chk("end_valid", 128'(kx_if.rk_valid_out), 128'(0));
        chk("end_key_ready", 128'(kx_if.key_ready_out), 128'(1));
        chk("end_busy", 128'(kx_if.busy_out), 128'(0));
        chk("end_index_hold", 128'(kx_if.rk_index_out), 128'(10));
        chk("end_rk_hold", kx_if.rk_out, exp_rk[10]);
        kx_if.key_in = '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst                = 1'b1;
        kx_if.key_valid_in = 1'b0;
        kx_if.key_in       = '0;
        kx_if.rk_ready_in  = 1'b0;
        init_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(kx_if.key_ready_out), 128'(1));
        chk("rst_rk_valid", 128'(kx_if.rk_valid_out), 128'(0));
        chk("rst_busy", 128'(kx_if.busy_out), 128'(0));
        chk("rst_rk_out", kx_if.rk_out, 128'h0);
        chk("rst_rk_index", 128'(kx_if.rk_index_out), 128'(0));
        rst = 1'b0;
        kx_if.rk_ready_in = 1'b1;
        tick();
        chk("idle_rk_valid", 128'(kx_if.rk_valid_out), 128'(0));

        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, 1'b0);
        chk("a1_idx1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_idx2", got_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("a1_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_schedule(128'h000102030405060708090a0b0c0d0e0f, -1, 1'b0);
        chk("c1_idx1", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk("c1_idx10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        run_schedule(rand128(), 3, 1'b0);
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, 1'b1);
        chk("poke_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Abort a schedule while index 5 is on the output.
        build_model(rand128());
        kx_if.key_in       = exp_rk[0];
        kx_if.key_valid_in = 1'b1;
        tick();
        kx_if.key_valid_in = 1'b0;
        repeat (5) tick();
        chk("pre_abort_index", 128'(kx_if.rk_index_out), 128'(5));
        chk("pre_abort_rk", kx_if.rk_out, exp_rk[5]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 128'(kx_if.rk_valid_out), 128'(0));
        chk("abort_busy", 128'(kx_if.busy_out), 128'(0));
        chk("abort_key_ready", 128'(kx_if.key_ready_out), 128'(1));
        tick();
        chk("abort_stays_idle", 128'(kx_if.rk_valid_out), 128'(0));
        run_schedule(rand128(), -1, 1'b0);

        for (int r = 0; r < 4; r++)
            run_schedule(rand128(), int'($urandom_range(0, 10)), r[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_expansion_128.md
Name: key_expansion_128

Overview:
Iterative AES-128 key schedule generator that sits directly upstream of the single-round encrypt stage and supplies its key_in.
- Accepts one 128-bit cipher key through a valid/ready handshake.
- Emits the 11 round keys (index 0..10) in order, one per accepted handshake, on a valid/ready output with backpressure.
- Computes one expansion step per cycle. S-box is a combinational lookup (4 instances on RotWord output), so there is no memory latency in the loop.

Parameters:
KEY_WIDTH, 128, cipher/round key width; only 128 supported.
NUM_ROUNDS, 10, last round-key index emitted; fixed for AES-128.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
key_valid_in  input  1  cipher key on key_in is valid
key_ready_out  output  1  block can accept a new cipher key (high only in IDLE)
key_in  input  KEY_WIDTH  cipher key; w0 = key_in[127:96] ... w3 = key_in[31:0]
rk_valid_out  output  1  rk_out/rk_index_out hold a valid round key
rk_ready_in  input  1  downstream accepts current round key
rk_out  output  KEY_WIDTH  current round key, same word ordering as key_in
rk_index_out  output  4  round index of rk_out, 0..10
busy_out  output  1  high while a schedule is in progress (EMIT state)

Behaviour:
- States: IDLE, EMIT.
- Reset (rst=1 at a rising edge):
  - state=IDLE; rk_valid_out=0, rk_out=0, rk_index_out=0, busy_out=0.
  - key_ready_out is decoded from state, so it is 1 from the first cycle after reset.
  - Reset mid-schedule aborts immediately; no further round keys are emitted.
- IDLE: key_ready_out=1. Key handshake (key_valid_in & key_ready_out) at edge T:
  - rk_out<=key_in, rk_index_out<=0, rk_valid_out<=1, state<=EMIT.
  - Round key 0 is visible in the cycle after T.
- EMIT:
  - key_ready_out=0. key_valid_in is ignored and no key is latched.
  - busy_out=1.
- Output handshake = rk_valid_out & rk_ready_in.
  - No handshake: rk_out, rk_index_out and rk_valid_out hold stable. No internal state advances.
  - Handshake with rk_index_out=k<10: rk_out<=next(rk_out,k+1), rk_index_out<=k+1, rk_valid_out stays 1.
  - Handshake with rk_index_out=10: rk_valid_out<=0, state<=IDLE, busy_out<=0. rk_out and rk_index_out retain their last values.
- next(W,i), where W = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}; RotWord({a,b,c,d}) = {b,c,d,a}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, selected from rk_index_out+1.
- Timing with rk_ready_in held high:
  - Key handshake at T gives index k valid in cycle T+1+k.
  - Index 10 is valid at T+11. rk_valid_out=0 and key_ready_out=1 at T+12.
  - Minimum spacing between key handshakes is 12 cycles.
- A new key cannot be accepted in the same cycle as the index-10 handshake.
- rk_ready_in while rk_valid_out=0 has no effect.
- Throughput: 1 round key/cycle; combinational path is one round of S-box plus XOR.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> key_ready_out=1, rk_valid_out=0, busy_out=0, rk_out=0.
- FIPS-197 A.1, rk_ready_in=1: key 2b7e151628aed2a6abf7158809cf4f3c at T ->
  - idx0 = key at T+1
  - idx1 = a0fafe1788542cb123a339392a6c7605 at T+2
  - idx2 = f2c295f27a96b9435935807a7359f67f
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11
  - key_ready_out=1 at T+12
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f ->
  - idx1 = d6aa74fdd2af72fadaa678f1d6ab76fe
  - idx10 = 13111d7fe3944a17f307a78b4d2b30c5
- Backpressure: hold rk_ready_in=0 for 5 cycles while idx3 is presented -> rk_out and rk_index_out=3 stable, rk_valid_out=1; release -> idx4 next cycle with the correct value.
- Key while busy: pulse key_valid_in with key ffff…ff during EMIT -> ignored, schedule of the original key completes unchanged.
- Reset mid-run: assert rst while idx5 is valid -> next cycle rk_valid_out=0, busy_out=0, key_ready_out=1; a new key then yields a correct full schedule.
